pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller: arbitrates stall requests from NREQ sources and flush requests from a resolving stage, and drives per-stage stall (freeze), bubble (NOP insert) and flush (squash) vectors for an NSTAGE-deep pipeline. It adds two things a plain combinational priority mux cannot provide:
- per-source post-request hold timers for multi-cycle operations;
- a deferred flush that waits out a stall in an older stage.

It sits beside the pipeline registers and replaces the fixed stall-bus decoder.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_src.sv | 84 ++++++++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: per-source FSM
// state encoding, reset polarity, the all-clear stall vector and the
// stage-index width helper.
package pipe_ctrl_pkg;

  // Per-source request tracker states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } src_state_t;

  // Level of rst that holds the block in reset.
  localparam logic RST_ACTIVE = 1'b0;

  // Upper bound on pipeline depth; NO_STALL is sliced down to NSTAGE bits.
  localparam int MAX_NSTAGE = 32;
  localparam logic [MAX_NSTAGE-1:0] NO_STALL = '0;

  // Width of a stage index; never narrower than one bit.
  function automatic int stage_width(input int nstage);
    return (nstage > 1) ? $clog2(nstage) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_src.sv
// One stall-request source: tracks the request level and, after the
// requester lets go, keeps stalling for the requested number of extra
// cycles. The cycle in which the request drops is the first hold cycle,
// so hold=h stalls for exactly h cycles after the drop and hold=0
// releases immediately.
module pipe_ctrl_src
  import pipe_ctrl_pkg::*;
#(
  parameter int SW    = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SW-1:0]    req_stage,
  input  logic [CNT_W-1:0] req_hold,
  input  logic             kill,
  output logic             eff_valid,
  output logic [SW-1:0]    eff_stage
);

  src_state_t       state_q, state_d;
  logic [SW-1:0]    ls_q, ls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, latched stage and hold counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= IDLE;
      ls_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples the pre-edge value of every other register.
      state_q <= state_d;
      ls_q    <= ls_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a valid request always (re)loads stage and hold.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    ls_d    = ls_q;
    cnt_d   = cnt_q;
    if (req_valid) begin
      state_d = ACTIVE;
      ls_d    = req_stage;
      cnt_d   = req_hold;
    end else begin
      unique case (state_q)
        IDLE: ;
        ACTIVE, HOLD: begin
          // The current cycle is already a stall cycle; leave when it is
          // the last one.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      // A flush that squashed the held stage ends the hold.
      if (kill) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Live request wins with zero latency; otherwise the latched stage while
  // hold cycles remain.
  assign eff_valid = req_valid || ((state_q != IDLE) && (cnt_q != '0));
  assign eff_stage = req_valid ? req_stage : ls_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller top. Merges NREQ stall sources into one
// thermometer stall vector with a bubble above the highest stalled stage,
// and issues squashes for a resolving stage, deferring a flush while an
// older-or-equal stage is stalled.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall-cycle and
// issued-flush counters; control behaviour does not depend on it.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int NSTAGE = 5,
  parameter  int NREQ   = 4,
  parameter  int CNT_W  = 4,
  localparam int SW     = stage_width(NSTAGE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*SW-1:0]    req_stage_i,
  input  logic [NREQ*CNT_W-1:0] req_hold_i,
  input  logic                  flush_i,
  input  logic [SW-1:0]         flush_stage_i,
  output logic [NSTAGE-1:0]     stall_o,
  output logic [NSTAGE-1:0]     bubble_o,
  output logic [NSTAGE-1:0]     flush_o,
  output logic                  flush_pend_o,
  output logic                  stall_any_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [15:0]           flush_cnt_o
`endif
);

  // Out-of-range stage indices collapse onto the oldest stage.
  function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
    if (int'(s) > NSTAGE - 1) return SW'(NSTAGE - 1);
    return s;
  endfunction

  logic [SW-1:0]   stage_c   [NREQ];
  logic [SW-1:0]   eff_stage [NREQ];
  logic [NREQ-1:0] eff_valid;
  logic [NREQ-1:0] kill;

  logic            k_valid;
  logic [SW-1:0]   k_stage;

  logic            fin_valid;
  logic [SW-1:0]   fin_stage;
  logic            f_valid;
  logic [SW-1:0]   f_stage;
  logic            flush_issue;
  logic            flush_defer;

  logic            pend_valid_q;
  logic [SW-1:0]   pend_stage_q;

  // One request tracker per source.
  for (genvar s = 0; s < NREQ; s++) begin : g_src
    assign stage_c[s] = clamp_stage(req_stage_i[s*SW +: SW]);

    // An issued flush kills a released (holding) source whose stage it squashes.
    assign kill[s] = flush_issue && !req_valid_i[s] && eff_valid[s] &&
                     (eff_stage[s] < f_stage);

    pipe_ctrl_src #(
      .SW    (SW),
      .CNT_W (CNT_W)
    ) u_src (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid_i[s]),
      .req_stage (stage_c[s]),
      .req_hold  (req_hold_i[s*CNT_W +: CNT_W]),
      .kill      (kill[s]),
      .eff_valid (eff_valid[s]),
      .eff_stage (eff_stage[s])
    );
  end

  // K: oldest stage any source currently wants frozen.
  always_comb begin
    k_valid = 1'b0;
    k_stage = '0;
    for (int s = 0; s < NREQ; s++) begin
      if (eff_valid[s] && (!k_valid || (eff_stage[s] > k_stage))) begin
        k_valid = 1'b1;
        k_stage = eff_stage[s];
      end
    end
  end

  // F: merge the new flush with any pending one; issue only if nothing at
  // or above F is stalled, otherwise park it.
  always_comb begin
    fin_valid = flush_i && (flush_stage_i != '0);
    fin_stage = clamp_stage(flush_stage_i);
    f_valid   = fin_valid || pend_valid_q;
    f_stage   = '0;
    if (fin_valid) f_stage = fin_stage;
    if (pend_valid_q && (pend_stage_q > f_stage)) f_stage = pend_stage_q;
    flush_issue = f_valid && (!k_valid || (k_stage < f_stage));
    flush_defer = f_valid && !flush_issue;
  end

  // Deferred-flush register: holds the deepest flush stage still waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      pend_valid_q <= 1'b0;
      pend_stage_q <= '0;
    end else if (flush_issue) begin
      pend_valid_q <= 1'b0;
      pend_stage_q <= '0;
    end else if (flush_defer) begin
      pend_valid_q <= 1'b1;
      pend_stage_q <= f_stage;
    end
  end

  // Stall thermometer, bubble above K, squash below F; all quiet in reset.
  always_comb begin
    stall_o  = NO_STALL[NSTAGE-1:0];
    bubble_o = NO_STALL[NSTAGE-1:0];
    flush_o  = NO_STALL[NSTAGE-1:0];
    if (rst != RST_ACTIVE) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (k_valid && (i <= int'(k_stage)))     stall_o[i]  = 1'b1;
        if (k_valid && (i == int'(k_stage) + 1)) bubble_o[i] = 1'b1;
        // Squashed stages neither freeze nor take a bubble.
        if (flush_issue && (i < int'(f_stage))) begin
          flush_o[i]  = 1'b1;
          stall_o[i]  = 1'b0;
          bubble_o[i] = 1'b0;
        end
      end
    end
  end

  assign stall_any_o  = |stall_o;
  assign flush_pend_o = pend_valid_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (stall_any_o && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_issue && (flush_cnt_q != '1))    flush_cnt_q    <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. A behavioural model tracks, per source,
// the number of stall cycles still owed after release, plus any parked
// flush, and derives the expected output vectors each cycle. Directed
// scenarios also compare against literal expected vectors.
module tb_pipe_ctrl;

  localparam int NSTAGE = 5;
  localparam int NREQ   = 4;
  localparam int CNT_W  = 4;
  localparam int SW     = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*SW-1:0]    req_stage;
  logic [NREQ*CNT_W-1:0] req_hold;
  logic                  flush_i;
  logic [SW-1:0]         flush_stage;
  logic [NSTAGE-1:0]     stall_o, bubble_o, flush_o;
  logic                  flush_pend_o, stall_any_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]           stall_cycles_o;
  logic [15:0]           flush_cnt_o;
`endif

  pipe_ctrl #(.NSTAGE(NSTAGE), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_stage_i   (req_stage),
    .req_hold_i    (req_hold),
    .flush_i       (flush_i),
    .flush_stage_i (flush_stage),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .flush_o       (flush_o),
    .flush_pend_o  (flush_pend_o),
    .stall_any_o   (stall_any_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o(stall_cycles_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: remaining post-release stall cycles and held stage per source.
  int     rem [NREQ];
  int     hs  [NREQ];
  bit     pend_v;
  int     pend_f;
  longint m_stall_cycles;
  int     m_flush_cnt;
  logic [3*NSTAGE+1:0] exp_vec;

  function automatic int clamp(input int s);
    return (s > NSTAGE - 1) ? NSTAGE - 1 : s;
  endfunction

  function automatic logic [3*NSTAGE+1:0] obs();
    return {stall_o, bubble_o, flush_o, flush_pend_o, stall_any_o};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NREQ; s++) begin
      rem[s] = 0;
      hs[s]  = 0;
    end
    pend_v = 0;
    pend_f = 0;
    m_stall_cycles = 0;
    m_flush_cnt = 0;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_stage   = '0;
    req_hold    = '0;
    flush_i     = 1'b0;
    flush_stage = '0;
  endtask

  task automatic set_req(input int s, input bit v, input int st, input int h);
    req_valid[s]              = v;
    req_stage[s*SW +: SW]     = SW'(st);
    req_hold[s*CNT_W +: CNT_W] = CNT_W'(h);
  endtask

  task automatic set_flush(input bit v, input int st);
    flush_i     = v;
    flush_stage = SW'(st);
  endtask

  // Settle inputs, compute expected outputs, then advance the model to the
  // state it will have after the coming rising edge.
  task automatic model_cycle();
    int  k, f, fin, st;
    int  eff [NREQ];
    bit  issue;
    logic [NSTAGE-1:0] es, eb, ef;
    #1;
    k = -1;
    for (int s = 0; s < NREQ; s++) begin
      st = clamp(int'(req_stage[s*SW +: SW]));
      if (req_valid[s])    eff[s] = st;
      else if (rem[s] > 0) eff[s] = hs[s];
      else                 eff[s] = -1;
      if (eff[s] > k) k = eff[s];
    end
    fin = (flush_i && flush_stage != 0) ? clamp(int'(flush_stage)) : 0;
    f = (pend_v && pend_f > fin) ? pend_f : fin;
    issue = (f > 0) && (k < f);
    es = '0; eb = '0; ef = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (k >= 0 && i <= k)     es[i] = 1'b1;
      if (k >= 0 && i == k + 1) eb[i] = 1'b1;
      if (issue && i < f) begin
        ef[i] = 1'b1;
        es[i] = 1'b0;
        eb[i] = 1'b0;
      end
    end
    exp_vec = {es, eb, ef, pend_v, |es};
    for (int s = 0; s < NREQ; s++) begin
      if (req_valid[s]) begin
        rem[s] = int'(req_hold[s*CNT_W +: CNT_W]);
        hs[s]  = clamp(int'(req_stage[s*SW +: SW]));
      end else if (rem[s] > 0) begin
        if (issue && hs[s] < f) rem[s] = 0;
        else                    rem[s] = rem[s] - 1;
      end
    end
    if (issue) pend_v = 0;
    else if (f > 0) begin
      pend_v = 1;
      pend_f = f;
    end
    if (|es && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
    if (issue && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %b want all zero", obs());
    end
    checks++;
    set_req(0, 1, 2, 3);
    set_flush(1, 2);
    #1;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_inputs_active: got %b want all zero", obs());
    end
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    if (stall_cycles_o !== 32'd0 || flush_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cycles_o, flush_cnt_o);
    end
    checks++;
`endif
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_plan_stall();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_req(0, c < 3, 2, 0);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL plan_stall_model c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
      if (stall_o !== (c < 3 ? 5'b00111 : 5'b0) || bubble_o !== (c < 3 ? 5'b01000 : 5'b0)) begin
        errors++;
        $display("FAIL plan_stall_vec c%0d: got s=%b b=%b", c, stall_o, bubble_o);
      end
      checks++;
    end
  endtask

  task automatic test_hold();
    // Valid for cycles 0-1, dropped at cycle 2 (t); stall through t+3.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      set_req(1, c < 2, 3, 4);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL hold_model c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
      if (stall_o !== (c <= 5 ? 5'b01111 : 5'b0) || bubble_o !== (c <= 5 ? 5'b10000 : 5'b0)) begin
        errors++;
        $display("FAIL hold_vec c%0d: got s=%b b=%b", c, stall_o, bubble_o);
      end
      checks++;
    end
  endtask

  task automatic test_flush_nostall();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      set_flush(c == 0, 2);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL flush_nostall_model c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
      if (flush_o !== (c == 0 ? 5'b00011 : 5'b0) || flush_pend_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_nostall_vec c%0d: got f=%b p=%b", c, flush_o, flush_pend_o);
      end
      checks++;
    end
    set_flush(0, 0);
  endtask

  task automatic test_deferred_flush();
    logic [NSTAGE-1:0] want_f;
    logic              want_p;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_req(2, c < 4, 4, 0);
      set_flush(c == 0 || c == 2, c == 0 ? 2 : 3);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL deferred_model c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
      want_f = (c == 4) ? 5'b00111 : 5'b0;
      want_p = (c >= 1 && c <= 4);
      if (flush_o !== want_f || flush_pend_o !== want_p) begin
        errors++;
        $display("FAIL deferred_vec c%0d: got f=%b p=%b want f=%b p=%b",
                 c, flush_o, flush_pend_o, want_f, want_p);
      end
      checks++;
    end
    set_flush(0, 0);
  endtask

  task automatic test_hold_kill();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_req(0, c == 0, 1, 6);
      set_flush(c == 2, 3);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL hold_kill_model c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
      if (c == 2 && (flush_o !== 5'b00111 || stall_o !== 5'b0)) begin
        errors++;
        $display("FAIL hold_kill_issue: got f=%b s=%b want f=00111 s=00000", flush_o, stall_o);
      end
      if (c >= 3 && stall_o !== 5'b0) begin
        errors++;
        $display("FAIL hold_kill_after c%0d: got s=%b want 00000", c, stall_o);
      end
      if (c >= 2) checks++;
    end
    set_flush(0, 0);
  endtask

  task automatic test_reset_mid_hold();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_req(1, c == 0, 3, 9);
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL midhold_setup c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL midhold_reset: got %b want all zero", obs());
    end
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    if (stall_cycles_o !== 32'd0 || flush_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL midhold_perf: got %0d/%0d want 0/0", stall_cycles_o, flush_cnt_o);
    end
    checks++;
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      model_cycle();
      if (obs() !== exp_vec || stall_o !== 5'b0) begin
        errors++;
        $display("FAIL midhold_release c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int s = 0; s < NREQ; s++) begin
        if ($urandom_range(3, 0) == 0) req_valid[s] = ~req_valid[s];
        req_stage[s*SW +: SW]      = SW'($urandom_range(7, 0));
        req_hold[s*CNT_W +: CNT_W] = CNT_W'($urandom_range(15, 0));
      end
      set_flush($urandom_range(5, 0) == 0, int'($urandom_range(7, 0)));
      model_cycle();
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", c, obs(), exp_vec);
      end
      checks++;
    end
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    clear_inputs();
    if (longint'(stall_cycles_o) !== m_stall_cycles || int'(flush_cnt_o) !== m_flush_cnt) begin
      errors++;
      $display("FAIL random_perf: got %0d/%0d want %0d/%0d",
               stall_cycles_o, flush_cnt_o, m_stall_cycles, m_flush_cnt);
    end
    checks++;
`endif
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_plan_stall();
    test_hold();
    test_flush_nostall();
    test_deferred_flush();
    test_hold_kill();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
